// File: rtl/xy_sched_pkg.sv
// Shared types and constants for the XY vector scheduler.
package xy_sched_pkg;

  localparam int unsigned DEPTH      = 32;
  localparam int unsigned GAP_CYCLES = 16;

  // Display-list entry layout: {blank, y[6:0], x[7:0]}.
  localparam int unsigned BLANK_BIT = 15;
  localparam int unsigned Y_MSB     = 14;
  localparam int unsigned Y_LSB     = 8;
  localparam int unsigned X_MSB     = 7;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDwell,
    StGap
  } state_e;

endpackage

// File: rtl/xy_point_ram.sv
// Display-list storage: one synchronous write port, one asynchronous read port, no reset.
module xy_point_ram #(
  parameter int unsigned Depth = 32,
  parameter int unsigned AddrW = 5
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [15:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [15:0]      rdata_o
);

  logic [15:0] mem_q [Depth];

  // Write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/xy_vector_scheduler.sv
// Plays a display list of XY points onto the BNC outputs with per-point dwell and blanking.
module xy_vector_scheduler
  import xy_sched_pkg::*;
#(
  parameter int unsigned Depth     = DEPTH,
  parameter int unsigned GapCycles = GAP_CYCLES,
  localparam int unsigned AddrW    = $clog2(Depth),
  localparam int unsigned LenW     = AddrW + 1,
  localparam int unsigned GapW     = (GapCycles > 1) ? $clog2(GapCycles) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [15:0]      wr_data_i,
  input  logic             run_i,
  input  logic [LenW-1:0]  list_len_i,
  input  logic [3:0]       dwell_i,
  output logic [7:0]       bnc_x_o,
  output logic [6:0]       bnc_y_o,
  output logic             bnc_trig_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);
  localparam logic [LenW-1:0] LenMax  = LenW'(Depth);

  state_e          state_q, state_d;
  logic [AddrW-1:0] idx_q, idx_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [3:0]       dwell_q, dwell_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic             trig_q, trig_d;
  logic             done_q, done_d;

  logic [15:0]      rdata;
  logic [LenW-1:0]  len_clamped;
  logic             start;

  assign wr_ready_o  = (state_q == StIdle) || (state_q == StGap);
  assign len_clamped = (list_len_i > LenMax) ? LenMax : list_len_i;

  xy_point_ram #(
    .Depth (Depth),
    .AddrW (AddrW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_valid_i && wr_ready_o),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  // Next-state, counters and output-register updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    x_d     = x_q;
    y_d     = y_q;
    trig_d  = trig_q;
    done_d  = 1'b0;
    start   = 1'b0;

    unique case (state_q)
      StIdle: begin
        start = run_i;
      end
      StLoad: begin
        x_d     = rdata[X_MSB:0];
        y_d     = rdata[Y_MSB:Y_LSB];
        trig_d  = ~rdata[BLANK_BIT];
        cnt_d   = dwell_q;
        state_d = StDwell;
      end
      StDwell: begin
        if (cnt_q == 4'd0) begin
          trig_d = 1'b0;
          if ({1'b0, idx_q} == len_q - LenW'(1)) begin
            gap_d   = GapLast;
            done_d  = 1'b1;
            state_d = StGap;
          end else begin
            idx_d   = idx_q + AddrW'(1);
            state_d = StLoad;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          start = run_i;
          if (!run_i) begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame start: latch parameters; an empty list goes straight to another gap.
    if (start) begin
      len_d   = len_clamped;
      dwell_d = dwell_i;
      idx_d   = '0;
      if (len_clamped == '0) begin
        gap_d   = GapLast;
        done_d  = 1'b1;
        state_d = StGap;
      end else begin
        state_d = StLoad;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      x_q     <= x_d;
      y_q     <= y_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
    end
  end

  assign bnc_x_o      = x_q;
  assign bnc_y_o      = y_q;
  assign bnc_trig_o   = trig_q;
  assign busy_o       = (state_q != StIdle);
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_xy_vector_scheduler.sv
// Directed bench for xy_vector_scheduler with hand-computed expectations.
module tb_xy_vector_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        run;
  logic [5:0]  list_len;
  logic [3:0]  dwell;
  logic [7:0]  bnc_x;
  logic [6:0]  bnc_y;
  logic        bnc_trig;
  logic        busy;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  int ex_x [4] = '{10, 200, 0, 255};
  int ex_y [4] = '{20, 100, 0, 127};

  xy_vector_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .run_i        (run),
    .list_len_i   (list_len),
    .dwell_i      (dwell),
    .bnc_x_o      (bnc_x),
    .bnc_y_o      (bnc_y),
    .bnc_trig_o   (bnc_trig),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input bit blank, input int x, input int y);
    wr_valid = 1'b1;
    wr_addr  = 5'(addr);
    wr_data  = {blank, 7'(y), 8'(x)};
    step();
    wr_valid = 1'b0;
  endtask

  // Entered while sampling the LOAD cycle of point 0 (len=4, dwell=2); leaves on the
  // first sample after the gap.
  task automatic run_frame(input bit blank1, input bit inject, input int drop_p);
    int cyc;
    cyc = 0;
    for (int p = 0; p < 4; p++) begin
      check_eq("load_trig", bnc_trig, 0);
      check_eq("load_ready", wr_ready, 0);
      for (int d = 0; d < 3; d++) begin
        step();
        cyc++;
        check_eq("dwell_x", bnc_x, ex_x[p]);
        check_eq("dwell_y", bnc_y, ex_y[p]);
        check_eq("dwell_trig", bnc_trig, (p == 1 && blank1) ? 0 : 1);
        check_eq("dwell_ready", wr_ready, 0);
        check_eq("dwell_done", frame_done, 0);
        if (p == 0 && d == 0 && inject) begin
          wr_valid = 1'b1;
          wr_addr  = 5'd1;
          wr_data  = {1'b1, 7'd100, 8'd200};
        end
        if (p == drop_p && d == 0) run = 1'b0;
      end
      step();
      cyc++;
    end
    check_eq("gap0_done", frame_done, 1);
    check_eq("gap0_trig", bnc_trig, 0);
    check_eq("gap0_ready", wr_ready, 1);
    check_eq("gap0_x_hold", bnc_x, 255);
    for (int g = 1; g < 16; g++) begin
      step();
      cyc++;
      if (g == 1) wr_valid = 1'b0;
      check_eq("gap_done", frame_done, 0);
      check_eq("gap_trig", bnc_trig, 0);
      check_eq("gap_busy", busy, 1);
    end
    step();
    cyc++;
    check_eq("frame_period", cyc, 32);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    run      = 1'b0;
    list_len = '0;
    dwell    = '0;
    step();
    step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_x", bnc_x, 0);
    check_eq("rst_y", bnc_y, 0);
    check_eq("rst_trig", bnc_trig, 0);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_ready", wr_ready, 1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) write_entry(i, 1'b0, ex_x[i], ex_y[i]);

    // Frame 1: unblanked; entry 1 rewritten as blanked while DWELL holds off the write.
    list_len = 6'd4;
    dwell    = 4'd2;
    run      = 1'b1;
    step();
    check_eq("start_busy", busy, 1);
    run_frame(1'b0, 1'b1, 99);
    // Frame 2: new entry 1 is blanked; run drops during point index 2.
    check_eq("f2_busy", busy, 1);
    run_frame(1'b1, 1'b0, 2);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_ready", wr_ready, 1);
    check_eq("idle_x_hold", bnc_x, 255);
    check_eq("idle_y_hold", bnc_y, 127);

    // Reset mid-DWELL with dwell=3.
    dwell = 4'd3;
    run   = 1'b1;
    step();
    step();
    step();
    check_eq("pre_rst_trig", bnc_trig, 1);
    rst_n = 1'b0;
    step();
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_x", bnc_x, 0);
    check_eq("mid_rst_y", bnc_y, 0);
    check_eq("mid_rst_trig", bnc_trig, 0);
    rst_n = 1'b1;
    run   = 1'b0;
    step();
    check_eq("post_rst_busy", busy, 0);
    dwell = 4'd2;
    run   = 1'b1;
    step();
    run_frame(1'b1, 1'b0, 0);
    check_eq("post_rst_idle", busy, 0);

    // Empty list: gap-only frames of 16 cycles.
    list_len = 6'd0;
    run      = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step();
      check_eq("len0_done", frame_done, (i % 16 == 0) ? 1 : 0);
      check_eq("len0_trig", bnc_trig, 0);
      check_eq("len0_busy", busy, 1);
      if (i == 47) run = 1'b0;
    end
    step();
    check_eq("len0_idle", busy, 0);

    // Oversized length clamps to 32 points of 2 cycles each.
    list_len = 6'd40;
    dwell    = 4'd0;
    run      = 1'b1;
    step();
    n = 0;
    while (!frame_done && n < 200) begin
      step();
      n++;
    end
    check_eq("len40_points", n, 64);
    run = 1'b0;
    n   = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check_eq("len40_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xy_vector_scheduler.md
# xy_vector_scheduler

Sequences the XY (oscilloscope/BNC) output path from a writable display list. Replaces the fixed per-cycle waveform table with a point list of up to 32 entries. Each point is held for a programmable dwell and gated by a per-point blank bit on the trigger/Z line. Sits between the host-side register interface and the BNC PMOD output mux, driving BNC_x/BNC_y/BNC_trig.

## Interface
- DEPTH, 32, display-list entries (address width 5)
- GAP_CYCLES, 16, blanked inter-frame cycles
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wr_valid  in  1  list write request
- wr_ready  out  1  list write accepted when high together with wr_valid
- wr_addr  in  5  entry index
- wr_data  in  16  entry {blank[15], y[14:8], x[7:0]}
- run  in  1  level; enables frame playback
- list_len  in  6  points per frame, 0..32; values >32 clamp to 32
- dwell  in  4  extra hold cycles per point
- bnc_x  out  8  X DAC code
- bnc_y  out  7  Y DAC code
- bnc_trig  out  1  beam enable/trigger, high while an unblanked point is held
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of each frame's last point

## Operation
- States: IDLE, LOAD, DWELL, GAP.
- IDLE: outputs hold; wr_ready=1. If run=1, latch list_len (clamped) and dwell into len_q/dwell_q, idx=0, go LOAD. If len_q=0, go directly to GAP and pulse frame_done.
- LOAD (1 cycle): read entry[idx]; register x/y/blank into output regs at the end of the cycle; bnc_trig=0; wr_ready=0.
- DWELL: hold the point for dwell_q+1 cycles; bnc_trig=~blank; wr_ready=0. On the last cycle: if idx=len_q-1, go GAP and pulse frame_done; else idx+1 and go LOAD.
- GAP: GAP_CYCLES cycles; bnc_trig=0; bnc_x/bnc_y hold the last point; wr_ready=1. On exit: if run=1, re-latch list_len/dwell, idx=0, go LOAD (or GAP again with a frame_done pulse if len=0); else go IDLE.
- run deassert mid-frame: the current frame completes through GAP, then the block enters IDLE. No truncation.
- Writes are accepted only when wr_valid & wr_ready. The memory updates on that clock edge. A write in the last GAP cycle is visible to the following LOAD.
- Widths: idx is 5 bits; len_q is 6 bits; the compare uses len_q-1 in 6 bits. The dwell counter is 4 bits and counts down from dwell_q.

## Timing
- Reset: state=IDLE, bnc_x=0, bnc_y=0, bnc_trig=0, busy=0, frame_done=0, idx=0.
- Reset has priority over all inputs and takes effect mid-frame on the next edge. List memory is not reset; its contents persist across reset and are undefined at power-up.
- run=1 sampled in IDLE at edge N: LOAD in cycle N+1, point 0 visible on bnc_x/bnc_y and bnc_trig in cycle N+2.
- Per point: 1 LOAD cycle plus (dwell_q+1) DWELL cycles.
- Frame period: len_q×(dwell_q+2) + GAP_CYCLES cycles. For len_q=0, the period is GAP_CYCLES.
- frame_done is high for exactly the first GAP cycle.
- All outputs are registered; there is no combinational path from inputs to outputs except wr_ready, which decodes state only.

## Structure
- Shared package xy_sched_pkg: state enum; entry field offsets (BLANK_BIT=15, Y_MSB=14, Y_LSB=8, X_MSB=7); DEPTH and GAP_CYCLES defaults.
- Sub-module xy_point_ram: DEPTH×16 register file, one synchronous write port and one asynchronous read port, no reset.
- The top-level FSM and counters live in xy_vector_scheduler.

## Test plan
- Reset mid-DWELL with dwell=3 → next cycle state=IDLE, bnc_x=0, bnc_y=0, bnc_trig=0, busy=0; list contents still readable on the next run.
- Load 4 points {x=10,y=20}, {x=200,y=100}, {x=0,y=0}, {x=255,y=127}; set len=4, dwell=2, run=1 → each point held 3 cycles with bnc_trig=1, 1-cycle trig=0 LOAD gaps, frame_done at cycle 16, next frame starts after 16 GAP cycles.
- Entry 1 with blank=1 → bnc_trig stays 0 for all of point 1's DWELL while bnc_x=200, bnc_y=100.
- wr_valid held during DWELL → wr_ready=0 and no memory change; the write is accepted in the first GAP cycle and the new value appears in the next frame.
- len=0, run=1 → busy=1, bnc_trig never high, frame_done pulses every 16 cycles; len=40 behaves as 32.
- run dropped during point 2 of 4 → points 3 and 4 still played, GAP completes, then IDLE with busy=0.
